// File: rtl/router_1xn.sv
`default_nettype none
// ----------------------------------------------------------------------------
// router_1xn : 1xN byte-serial packet router, one FIFO per destination port
// Rev 1.0
// ----------------------------------------------------------------------------
module router_1xn #(
  parameter int DW        = 8,
  parameter int NUM_PORTS = 3,
  parameter int AW        = 2,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 30
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [DW-1:0]           data_in,
  input  logic                    pkt_vld,
  input  logic [NUM_PORTS-1:0]    read_enb,
  output logic [NUM_PORTS*DW-1:0] data_out,
  output logic [NUM_PORTS-1:0]    vld_out,
  output logic                    busy,
  output logic                    err,
  output logic [1:0]              err_code
);
  localparam int LW = DW - AW;
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NA = 1 << AW;
  localparam logic [AW:0]   NP_LIM   = (AW+1)'(NUM_PORTS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DROP  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] par_q, par_d;
  logic [LW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic [NA-1:0] empty_v, full_v;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] hdr_addr;
  logic          hdr_ok;

  assign hdr_addr = data_in[AW-1:0];
  assign hdr_ok   = {1'b0, hdr_addr} < NP_LIM;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    code_d  = 2'b00;
    busy    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        wr_addr = hdr_addr;
        // The source holds the header stable while busy, so WAIT re-decodes data_in.
        if (pkt_vld || state_q == S_WAIT) begin
          if (!hdr_ok) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_DROP;
          end else if (empty_v[hdr_addr]) begin
            wr_en   = 1'b1;
            addr_d  = hdr_addr;
            len_d   = data_in[DW-1:AW];
            par_d   = data_in;
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            busy    = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_LOAD: begin
        if (full_v[addr_q]) begin
          busy = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (pkt_vld) begin
            par_d = par_q ^ data_in;
            if (cnt_q != '1) cnt_d = cnt_q + (LW+1)'(1);
          end else begin
            state_d = S_CHECK;
            if (par_q != data_in) begin
              err_d  = 1'b1;
              code_d = 2'b01;
            end else if (cnt_q != {1'b0, len_q}) begin
              err_d  = 1'b1;
              code_d = 2'b10;
            end
          end
        end
      end
      S_DROP: begin
        if (!pkt_vld) state_d = S_IDLE;
      end
      S_CHECK: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign err      = err_q;
  assign err_code = code_q;

  for (genvar j = NUM_PORTS; j < NA; j++) begin : g_pad
    assign empty_v[j] = 1'b1;
    assign full_v[j]  = 1'b0;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          empty, full, we, re, flush;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign we    = wr_en && (wr_addr == AW'(i));
    assign re    = read_enb[i] && !empty;
    // Flush on the edge that would complete TIMEOUT unread cycles; it overrides a same-cycle write.
    assign flush = !empty && !read_enb[i] && (tmo_q == TMO_LAST);

    always_comb begin
      wp_d   = wp_q + (PW+1)'(we);
      rp_d   = rp_q + (PW+1)'(re);
      tmo_d  = (!empty && !read_enb[i]) ? tmo_q + TW'(1) : '0;
      dout_d = re ? mem_q[rp_q[PW-1:0]] : dout_q;
      if (flush) begin
        wp_d  = '0;
        rp_d  = '0;
        tmo_d = '0;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wp_q   <= '0;
        rp_q   <= '0;
        tmo_q  <= '0;
        dout_q <= '0;
      end else begin
        wp_q   <= wp_d;
        rp_q   <= rp_d;
        tmo_q  <= tmo_d;
        dout_q <= dout_d;
      end
    end

    always_ff @(posedge clock) begin
      if (we) mem_q[wp_q[PW-1:0]] <= data_in;
    end

    assign empty_v[i]             = empty;
    assign full_v[i]              = full;
    assign vld_out[i]             = !empty;
    assign data_out[i*DW +: DW]   = dout_q;
  end
endmodule
`default_nettype wire
